// File: rtl/sseg_x4_driver.sv
`default_nettype none
// ============================================================================
// Module   : sseg_x4_driver
// Purpose  : Time-multiplexed driver for a 4-digit common-anode 7-segment
//            display. Each digit slot starts with an anti-ghost blank window,
//            then drives one anode. Optional leading-zero suppression.
//            A new value is captured once per frame.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_x4_driver #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        lzs,
  output logic [6:0]  sseg_ca,
  output logic [3:0]  sseg_an,
  output logic        frame_done
);

  localparam int            CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] PRESC_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    CA_OFF    = 7'h7F;
  localparam logic [3:0]    AN_OFF    = 4'hF;

  logic [CW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic [15:0]   shadow_value;
  logic          shadow_lzs;

  logic          frame_start;
  logic          frame_end;
  logic          slot_end;
  logic          in_blank;
  logic          suppress;
  logic [15:0]   cur_value;
  logic          cur_lzs;
  logic [3:0]    nibble;
  logic [6:0]    seg;
  logic [6:0]    ca_next;
  logic [3:0]    an_next;

  assign frame_start = (prescaler == '0) && (digit_idx == 2'd0);
  assign slot_end    = (prescaler == PRESC_MAX);
  assign frame_end   = slot_end && (digit_idx == 2'd3);

  // The slot that latches the shadow registers must already display the
  // freshly latched data (matters when there is no blank window).
  assign cur_value = frame_start ? value : shadow_value;
  assign cur_lzs   = frame_start ? lzs   : shadow_lzs;

  // The blank window vanishes entirely when no blank cycles are configured.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
      assign in_blank = (prescaler < BLANK_LIM);
    end
  endgenerate

  // Select the nibble and decide leading-zero suppression for this slot.
  always_comb begin
    nibble   = cur_value[3:0];
    suppress = 1'b0;
    case (digit_idx)
      2'd0: begin
        nibble   = cur_value[3:0];
        suppress = 1'b0;
      end
      2'd1: begin
        nibble   = cur_value[7:4];
        suppress = cur_lzs && (cur_value[15:4] == 12'h000);
      end
      2'd2: begin
        nibble   = cur_value[11:8];
        suppress = cur_lzs && (cur_value[15:8] == 8'h00);
      end
      default: begin
        nibble   = cur_value[15:12];
        suppress = cur_lzs && (cur_value[15:12] == 4'h0);
      end
    endcase
  end

  // Hex to active-low segment decode (bit 0 = a ... bit 6 = g).
  always_comb begin
    seg = CA_OFF;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

  // Next anode/cathode pattern for the current prescaler/index state.
  always_comb begin
    an_next = AN_OFF;
    ca_next = CA_OFF;
    if (!in_blank && !suppress) begin
      an_next = ~(4'b0001 << digit_idx);
      ca_next = seg;
    end
  end

  // Slot timing, frame capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler    <= '0;
      digit_idx    <= 2'd0;
      shadow_value <= 16'h0000;
      shadow_lzs   <= 1'b0;
      sseg_an      <= AN_OFF;
      sseg_ca      <= CA_OFF;
      frame_done   <= 1'b0;
    end else if (!en) begin
      prescaler    <= '0;
      digit_idx    <= 2'd0;
      sseg_an      <= AN_OFF;
      sseg_ca      <= CA_OFF;
      frame_done   <= 1'b0;
    end else begin
      if (frame_start) begin
        shadow_value <= value;
        shadow_lzs   <= lzs;
      end
      if (slot_end) begin
        prescaler <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      sseg_an    <= an_next;
      sseg_ca    <= ca_next;
      frame_done <= frame_end;
    end
  end

endmodule
`default_nettype wire

// File: doc/sseg_x4_driver.md
SSEG_X4_DRIVER -- requirements
Module: sseg_x4_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100_000, giving clocks per digit slot (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1_000, giving the anti-ghost blank clocks at the start of each slot; legal range 0..REFRESH_DIV-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic sits in this one clock domain.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1, display enable.
REQ-006 SHALL have port value, input, 16, the four hex digits; digit i is value[4i+3:4i], and digit 0 is rightmost.
REQ-007 SHALL have port lzs, input, 1, leading-zero suppression enable.
REQ-008 SHALL have port sseg_ca, output, 7, cathodes, active-low, bit 0=a through bit 6=g.
REQ-009 SHALL have port sseg_an, output, 4, anodes, active-low; bit i selects digit i.
REQ-010 SHALL have port frame_done, output, 1, a one-clock pulse at the end of each full 4-digit frame.

Function
REQ-011 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-012 SHALL run a prescaler counting 0..REFRESH_DIV-1 that wraps to 0; each wrap advances digit index 0->1->2->3->0.
REQ-013 SHALL drive each slot in two phases:
  - BLANK, prescaler < BLANK_CYCLES: sseg_an=4'hF and sseg_ca=7'h7F.
  - DRIVE, the remaining cycles: exactly one anode bit low, at the current digit index.
REQ-014 SHALL skip BLANK and make every cycle DRIVE when BLANK_CYCLES=0.
REQ-015 SHALL latch value and lzs into shadow registers on the clock where the prescaler is 0 and the digit index is 0; changes mid-frame SHALL NOT appear until the next frame.
REQ-016 SHALL encode hex to sseg_ca (hex 7'h) as follows: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-017 SHALL, when shadow lzs=1, blank digit k in 1..3 whenever shadow digits k..3 are all zero: anodes stay 4'hF and sseg_ca=7'h7F during that slot's DRIVE phase.
REQ-018 SHALL never suppress digit 0.
REQ-019 SHALL keep slot timing of suppressed digits unchanged.
REQ-020 SHALL assert frame_done for exactly the one clock where the prescaler is REFRESH_DIV-1 and the digit index is 3.
REQ-021 SHALL, when en=0 is sampled:
  - return the prescaler and digit index to 0 synchronously;
  - force sseg_an=4'hF and sseg_ca=7'h7F;
  - hold frame_done=0.
REQ-022 SHALL, on the first clock with en=1, start a BLANK phase of digit 0 with the prescaler at 0, and latch the shadow registers on that clock.
REQ-023 SHALL apply output updates one clock after the prescaler/index state they reflect, uniformly for all phases, so a DRIVE phase lasts exactly REFRESH_DIV-BLANK_CYCLES clocks.

Reset
REQ-024 SHALL, while rst=1 and independent of clk, hold the following: sseg_an=4'hF, sseg_ca=7'h7F, frame_done=0, prescaler=0, digit index=0, shadow value=16'h0000, shadow lzs=0.
REQ-025 SHALL, on the first clock after rst falls with en=1, behave as REQ-022.
REQ-026 SHALL, on rst asserted mid-slot, blank the outputs immediately; after release the frame restarts at digit 0.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-027 SHALL check reset: assert rst mid-DRIVE -> sseg_an=4'hF and sseg_ca=7'h7F before the next clock edge; after release, digit 0 BLANK for 2 clocks, then DRIVE for 6.
REQ-028 SHALL check value=16'h1234, lzs=0 -> per-slot DRIVE (an,ca) pairs (1110,19),(1101,30),(1011,24),(0111,79); frame_done pulses once every 32 clocks.
REQ-029 SHALL check lzs=1 with value=16'h0070 -> digits 3 and 2 blanked (an=F, ca=7F); digit 1 gives (1101,78); digit 0 gives (1110,40). With value=16'h0000 only digit 0 is lit, showing 40.
REQ-030 SHALL check changing value from 16'h1234 to 16'hABCD during digit 1's slot -> digits 2 and 3 of that frame still show 2,1; the next frame shows D,C,B,A as 21,46,03,08.
REQ-031 SHALL check en dropped mid-frame for 5 clocks, then raised -> outputs F/7F with no frame_done while low; restart at digit 0 BLANK.
REQ-032 SHALL check BLANK_CYCLES=0 -> no all-high anode cycle between slots; each anode is low for exactly 8 consecutive clocks.
